// File: rtl/restador_seq_if.sv
// Handshake bus for the sequential subtractor: operand side (in_*), result side (out_*) and status.
interface restador_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] C;
    logic             borrow;
    logic             zero;
    logic             overflow;
    logic             busy;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, C, borrow, zero, overflow, busy
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, C, borrow, zero, overflow, busy
    );
endinterface

// File: rtl/restador_seq.sv
// Multi-cycle subtractor: C = A + ~B + 1, one SLICE-bit ripple slice per clock, LSB slice first.
// Optional macro RESTADOR_SAT_EN clamps C to zero on unsigned borrow.
module restador_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input logic           clk,
    input logic           rst_n,
    restador_seq_if.slave bus
);
    localparam int unsigned N     = WIDTH / SLICE;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SUM_W = SLICE + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] c_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic             sign_a_q;
    logic             sign_b_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             borrow_q;
    logic             zero_q;
    logic             overflow_q;

    logic [SLICE-1:0] a_sl_c;
    logic [SLICE-1:0] b_sl_c;
    logic [SUM_W-1:0] sum_c;
    logic [WIDTH-1:0] res_c;
    logic [WIDTH-1:0] c_fin_c;
    logic             borrow_c;
    int unsigned      base_c;

    // Current slice add and the result register as it will look after this slice.
    always_comb begin
        base_c   = 32'(idx_q) * SLICE;
        a_sl_c   = opa_q[base_c +: SLICE];
        b_sl_c   = opb_q[base_c +: SLICE];
        sum_c    = SUM_W'(a_sl_c) + SUM_W'(b_sl_c) + SUM_W'(carry_q);
        res_c    = res_q;
        res_c[base_c +: SLICE] = sum_c[SLICE-1:0];
        borrow_c = ~sum_c[SLICE];
`ifdef RESTADOR_SAT_EN
        c_fin_c  = borrow_c ? '0 : res_c;
`else
        c_fin_c  = res_c;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            opa_q       <= '0;
            opb_q       <= '0;
            res_q       <= '0;
            c_q         <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            borrow_q    <= 1'b0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        opa_q      <= bus.A;
                        opb_q      <= ~bus.B;
                        sign_a_q   <= bus.A[WIDTH-1];
                        sign_b_q   <= bus.B[WIDTH-1];
                        carry_q    <= 1'b1;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_CALC;
                    end
                end
                S_CALC: begin
                    res_q   <= res_c;
                    carry_q <= sum_c[SLICE];
                    idx_q   <= IDX_W'(idx_q + 1'b1);
                    if (idx_q == LAST_IDX) begin
                        // Flags use the raw difference; only C and zero see saturation.
                        c_q         <= c_fin_c;
                        borrow_q    <= borrow_c;
                        zero_q      <= (c_fin_c == '0);
                        overflow_q  <= (sign_a_q != sign_b_q) && (res_c[WIDTH-1] != sign_a_q);
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.C         = c_q;
    assign bus.borrow    = borrow_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = overflow_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_restador_seq.sv
// Directed plus randomized checks of restador_seq: latency, flags, backpressure, mid-CALC reset.
module tb_restador_seq;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned N     = 4;
`ifdef RESTADOR_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    restador_seq_if #(.WIDTH(WIDTH)) ifc ();

    restador_seq #(.WIDTH(WIDTH), .SLICE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raw C/borrow/overflow come from hand calculation; saturation adjusts C and zero.
    task automatic chk_result(input string tag, input logic [15:0] c_raw, input logic b,
                              input logic z_raw, input logic o);
        logic [15:0] ec;
        logic        ez;
        ec = (SAT && b) ? 16'h0000 : c_raw;
        ez = (SAT && b) ? 1'b1 : z_raw;
        chk({tag, "/C"},        32'(ifc.C),        32'(ec));
        chk({tag, "/borrow"},   32'(ifc.borrow),   32'(b));
        chk({tag, "/zero"},     32'(ifc.zero),     32'(ez));
        chk({tag, "/overflow"}, 32'(ifc.overflow), 32'(o));
    endtask

    // Full transaction with out_ready=1, checking exact latency and return to IDLE.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c_raw, input logic eb, input logic ez, input logic eo);
        ifc.out_ready = 1'b1;
        ifc.A         = a;
        ifc.B         = b;
        ifc.in_valid  = 1'b1;
        chk({tag, "/in_ready_pre"}, 32'(ifc.in_ready), 32'd1);
        tick();
        ifc.in_valid = 1'b0;
        ifc.A        = 16'hDEAD;
        ifc.B        = 16'hBEEF;
        chk({tag, "/busy"},     32'(ifc.busy),     32'd1);
        chk({tag, "/in_ready"}, 32'(ifc.in_ready), 32'd0);
        for (int i = 1; i < int'(N); i++) begin
            tick();
            chk({tag, "/early_valid"}, 32'(ifc.out_valid), 32'd0);
        end
        tick();
        chk({tag, "/out_valid"}, 32'(ifc.out_valid), 32'd1);
        chk_result(tag, c_raw, eb, ez, eo);
        tick();
        chk({tag, "/drained"},  32'(ifc.out_valid), 32'd0);
        chk({tag, "/idle_rdy"}, 32'(ifc.in_ready),  32'd1);
        chk({tag, "/idle_bsy"}, 32'(ifc.busy),      32'd0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] rc;
        logic        rbor;
        logic        rovf;
        logic        got;
        logic        seen;
        logic        consumed;
        int          cyc;

        n_vec         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b0;
        ifc.A         = 16'h0;
        ifc.B         = 16'h0;
        tick();
        tick();
        chk("rst/in_ready",  32'(ifc.in_ready),  32'd1);
        chk("rst/out_valid", 32'(ifc.out_valid), 32'd0);
        chk("rst/busy",      32'(ifc.busy),      32'd0);
        chk("rst/C",         32'(ifc.C),         32'd0);
        chk("rst/flags",     32'({ifc.borrow, ifc.zero, ifc.overflow}), 32'd0);
        rst_n = 1'b1;
        tick();

        do_op("basic", 16'h0010, 16'h0004, 16'h000C, 1'b0, 1'b0, 1'b0);
        do_op("neg",   16'h0004, 16'h0010, 16'hFFF4, 1'b1, 1'b0, 1'b0);
        do_op("ovf",   16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1);
        do_op("eq",    16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0);
        do_op("bzero", 16'hA5C3, 16'h0000, 16'hA5C3, 1'b0, 1'b0, 1'b0);
        do_op("zm1",   16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        do_op("ovf2",  16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 1'b1);

        // Backpressure: hold result in DONE while inputs wiggle.
        ifc.out_ready = 1'b0;
        ifc.A         = 16'h0050;
        ifc.B         = 16'h0020;
        ifc.in_valid  = 1'b1;
        tick();
        ifc.in_valid = 1'b0;
        for (int i = 0; i < int'(N); i++) tick();
        chk("bp/out_valid", 32'(ifc.out_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            ifc.in_valid = ~ifc.in_valid;
            ifc.A        = 16'h1111 * 16'(i + 1);
            ifc.B        = 16'h0F0F ^ 16'(i);
            tick();
            chk("bp/hold_valid", 32'(ifc.out_valid), 32'd1);
            chk("bp/hold_rdy",   32'(ifc.in_ready),  32'd0);
            chk_result("bp/hold", 16'h0030, 1'b0, 1'b0, 1'b0);
        end
        ifc.out_ready = 1'b1;
        ifc.in_valid  = 1'b1;
        ifc.A         = 16'h0007;
        ifc.B         = 16'h0002;
        tick();
        chk("bp/consumed", 32'(ifc.out_valid), 32'd0);
        chk("bp/rdy",      32'(ifc.in_ready),  32'd1);
        tick();
        ifc.in_valid = 1'b0;
        chk("bp/next_acc", 32'(ifc.busy), 32'd1);
        for (int i = 0; i < int'(N); i++) tick();
        chk("bp/next_valid", 32'(ifc.out_valid), 32'd1);
        chk_result("bp/next", 16'h0005, 1'b0, 1'b0, 1'b0);
        tick();

        // Reset while idx=2 in CALC.
        ifc.A        = 16'h1111;
        ifc.B        = 16'h0101;
        ifc.in_valid = 1'b1;
        tick();
        ifc.in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst/out_valid", 32'(ifc.out_valid), 32'd0);
        chk("mrst/C",         32'(ifc.C),         32'd0);
        chk("mrst/in_ready",  32'(ifc.in_ready),  32'd1);
        chk("mrst/busy",      32'(ifc.busy),      32'd0);
        do_op("post_rst", 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0);

        // Random pairs with random backpressure, checked against a reference computation.
        for (int t = 0; t < 50; t++) begin
            ra = 16'($urandom);
            rb = (t % 10 == 0) ? ra : 16'($urandom);
            ifc.A        = ra;
            ifc.B        = rb;
            ifc.in_valid = 1'b1;
            cyc = 0;
            while (!ifc.in_ready && cyc < 20) begin
                tick();
                cyc++;
            end
            if (!ifc.in_ready) chk("rnd/accept_timeout", 32'd0, 32'd1);
            tick();
            ifc.in_valid = 1'b0;
            rc   = ra - rb;
            rbor = (ra < rb);
            rovf = (ra[15] != rb[15]) && (rc[15] != ra[15]);
            got  = 1'b0;
            seen = 1'b0;
            cyc  = 0;
            while (!got && cyc < 60) begin
                if (ifc.out_valid && !seen) begin
                    chk_result("rnd", rc, rbor, (rc == 16'h0), rovf);
                    seen = 1'b1;
                end
                ifc.out_ready = 1'($urandom_range(0, 1));
                consumed      = ifc.out_valid && ifc.out_ready;
                tick();
                cyc++;
                if (consumed) got = 1'b1;
            end
            if (!got) chk("rnd/result_timeout", 32'd0, 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
